// File: rtl/layer2_weight_buffer.sv
`default_nettype none
// ============================================================================
// Module  : layer2_weight_buffer
// Brief   : Register-based weight table for the layer-2 RELU nodes; streamed
//           load with abort/restart, one-row-per-cycle read port.
// Revision: 1.0 - initial release
// ============================================================================
module layer2_weight_buffer #(
    parameter  int NODES   = 10,
    parameter  int WEIGHTS = 10,
    parameter  int WIDTH   = 8,
    localparam int IDXW    = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         load_data,
    output logic                     load_ready,
    output logic                     load_done,
    output logic                     loaded,
    input  logic                     rd_en,
    input  logic [IDXW-1:0]          rd_node,
    output logic [WEIGHTS*WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rd_error
);

    localparam int                c_WCNTW  = (WEIGHTS > 1) ? $clog2(WEIGHTS) : 1;
    localparam logic [c_WCNTW-1:0] c_WLAST = c_WCNTW'(WEIGHTS - 1);
    localparam logic [IDXW-1:0]    c_NLAST = IDXW'(NODES - 1);
    localparam logic [IDXW:0]      c_NODES = (IDXW + 1)'(NODES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    logic [0:0]               r_state;
    logic [0:0]               w_stateNext;
    logic [c_WCNTW-1:0]       r_weightCnt;
    logic [IDXW-1:0]          r_nodeCnt;
    logic                     r_loaded;
    logic                     r_loadDone;
    logic                     r_rdValid;
    logic                     r_rdError;
    logic [WEIGHTS*WIDTH-1:0] r_rdData;
    logic [WIDTH-1:0]         r_mem [NODES][WEIGHTS];

    logic                     w_accept;
    logic                     w_lastWeight;
    logic                     w_rdAccept;
    logic [WEIGHTS*WIDTH-1:0] w_rdRow;

    // A restart request wins over a weight presented in the same cycle.
    assign w_accept     = (r_state == S_LOAD) & load_valid & load_ready & ~load_start;
    assign w_lastWeight = (r_weightCnt == c_WLAST) & (r_nodeCnt == c_NLAST);
    assign w_rdAccept   = rd_en & r_loaded & ({1'b0, rd_node} < c_NODES);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_stateNext = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && w_lastWeight) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_ready = (r_state == S_LOAD);
    end

    // ---------------- Load counters and status ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_weightCnt <= '0;
            r_nodeCnt   <= '0;
            r_loaded    <= 1'b0;
            r_loadDone  <= 1'b0;
        end else begin
            r_loadDone <= 1'b0;
            if (load_start) begin
                r_weightCnt <= '0;
                r_nodeCnt   <= '0;
                r_loaded    <= 1'b0;
            end else if (w_accept) begin
                if (r_weightCnt == c_WLAST) begin
                    r_weightCnt <= '0;
                    if (r_nodeCnt == c_NLAST) begin
                        r_nodeCnt  <= '0;
                        r_loaded   <= 1'b1;
                        r_loadDone <= 1'b1;
                    end else begin
                        r_nodeCnt <= r_nodeCnt + 1'b1;
                    end
                end else begin
                    r_weightCnt <= r_weightCnt + 1'b1;
                end
            end
        end
    end

    // Storage keeps its contents across reset; only writes are blocked.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_mem[r_nodeCnt][r_weightCnt] <= load_data;
        end
    end

    // ---------------- Read path ----------------
    always_comb begin
        w_rdRow = '0;
        for (int i = 0; i < NODES; i++) begin
            if (rd_node == IDXW'(i)) begin
                for (int j = 0; j < WEIGHTS; j++) begin
                    w_rdRow[j*WIDTH +: WIDTH] = r_mem[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_rdError <= 1'b0;
        end else begin
            r_rdValid <= w_rdAccept;
            r_rdError <= rd_en & ~w_rdAccept;
            if (w_rdAccept) begin
                r_rdData <= w_rdRow;
            end
        end
    end

    assign load_done = r_loadDone;
    assign loaded    = r_loaded;
    assign rd_data   = r_rdData;
    assign rd_valid  = r_rdValid;
    assign rd_error  = r_rdError;

endmodule
`default_nettype wire

// File: tb/tb_layer2_weight_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer2_weight_buffer
// Brief   : Directed, table-driven bench for layer2_weight_buffer (10x10x8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_layer2_weight_buffer;

    localparam int NODES   = 10;
    localparam int WEIGHTS = 10;
    localparam int WIDTH   = 8;
    localparam int IDXW    = 4;

    logic                     clk;
    logic                     reset;
    logic                     load_start;
    logic                     load_valid;
    logic [WIDTH-1:0]         load_data;
    logic                     load_ready;
    logic                     load_done;
    logic                     loaded;
    logic                     rd_en;
    logic [IDXW-1:0]          rd_node;
    logic [WEIGHTS*WIDTH-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_error;

    layer2_weight_buffer #(
        .NODES   (NODES),
        .WEIGHTS (WEIGHTS),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .loaded     (loaded),
        .rd_en      (rd_en),
        .rd_node    (rd_node),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_error   (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdEn;
        logic [3:0]  node;
        logic        expValid;
        logic        expError;
        logic [79:0] expData;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          doneCnt  = 0;
    logic        early;
    logic [7:0]  expMem [10][10];
    vec_t        vecs [7];
    logic [79:0] allA5;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic checkData(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (load_done === 1'b1) doneCnt++;
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push(input int idx, input logic [7:0] v);
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
        expMem[idx / 10][idx % 10] = v;
    endtask

    function automatic logic [79:0] expRow(input int n);
        logic [79:0] r;
        for (int w = 0; w < 10; w++) r[w*8 +: 8] = expMem[n][w];
        return r;
    endfunction

    task automatic streamCheck(input string tag, input logic useA5);
        for (int i = 0; i < NODES; i++) begin
            rd_en   = 1'b1;
            rd_node = 4'(i);
            step();
            checkBit($sformatf("%s_valid_n%0d", tag, i), rd_valid, 1'b1);
            checkData($sformatf("%s_data_n%0d", tag, i), rd_data, useA5 ? allA5 : expRow(i));
        end
        rd_en = 1'b0;
        step();
        checkBit($sformatf("%s_valid_drop", tag), rd_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        allA5 = {10{8'hA5}};
        vecs[0] = '{1'b1, 4'd0,  1'b1, 1'b0, 80'h09080706050403020100};
        vecs[1] = '{1'b1, 4'd9,  1'b1, 1'b0, 80'h636261605F5E5D5C5B5A};
        vecs[2] = '{1'b1, 4'd12, 1'b0, 1'b1, 80'h636261605F5E5D5C5B5A};
        vecs[3] = '{1'b0, 4'd5,  1'b0, 1'b0, 80'h636261605F5E5D5C5B5A};
        vecs[4] = '{1'b1, 4'd10, 1'b0, 1'b1, 80'h636261605F5E5D5C5B5A};
        vecs[5] = '{1'b1, 4'd5,  1'b1, 1'b0, 80'h3B3A3938373635343332};
        vecs[6] = '{1'b1, 4'd15, 1'b0, 1'b1, 80'h3B3A3938373635343332};

        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        rd_en = 1'b0; rd_node = '0;
        step();
        step();
        reset = 1'b0;
        checkBit("rst_load_ready", load_ready, 1'b0);
        checkBit("rst_loaded", loaded, 1'b0);
        checkBit("rst_load_done", load_done, 1'b0);
        checkBit("rst_rd_valid", rd_valid, 1'b0);
        checkBit("rst_rd_error", rd_error, 1'b0);
        checkData("rst_rd_data", rd_data, 80'h0);

        // Read before any table is loaded.
        rd_en = 1'b1; rd_node = 4'd0;
        step();
        rd_en = 1'b0;
        checkBit("early_rd_error", rd_error, 1'b1);
        checkBit("early_rd_valid", rd_valid, 1'b0);
        checkData("early_rd_data", rd_data, 80'h0);
        step();
        checkBit("early_rd_error_pulse", rd_error, 1'b0);

        // Full contiguous load with value n*10+w.
        startLoad();
        checkBit("full_ready", load_ready, 1'b1);
        checkBit("full_loaded_clear", loaded, 1'b0);
        doneCnt = 0; early = 1'b0;
        for (int k = 0; k < 100; k++) begin
            push(k, 8'(k));
            if (k < 99 && (loaded || load_done)) early = 1'b1;
        end
        checkBit("full_early_loaded", early, 1'b0);
        checkBit("full_load_done", load_done, 1'b1);
        checkBit("full_loaded", loaded, 1'b1);
        checkBit("full_ready_idle", load_ready, 1'b0);
        step();
        checkBit("full_done_one_cycle", load_done, 1'b0);
        checkInt("full_done_count", doneCnt, 1);

        rd_en = 1'b1; rd_node = 4'd3;
        step();
        rd_en = 1'b0;
        checkBit("rd3_valid", rd_valid, 1'b1);
        checkBit("rd3_error", rd_error, 1'b0);
        checkData("rd3_data", rd_data, 80'h27262524232221201F1E);

        for (int i = 0; i < 7; i++) begin
            rd_en   = vecs[i].rdEn;
            rd_node = vecs[i].node;
            step();
            checkBit($sformatf("vec%0d_valid", i), rd_valid, vecs[i].expValid);
            checkBit($sformatf("vec%0d_error", i), rd_error, vecs[i].expError);
            checkData($sformatf("vec%0d_data", i), rd_data, vecs[i].expData);
        end
        rd_en = 1'b0;

        streamCheck("stream", 1'b0);

        // Read and restart together: old table serves the read.
        rd_en = 1'b1; rd_node = 4'd2; load_start = 1'b1;
        step();
        rd_en = 1'b0; load_start = 1'b0;
        checkBit("rdstart_valid", rd_valid, 1'b1);
        checkData("rdstart_data", rd_data, 80'h1D1C1B1A191817161514);
        checkBit("rdstart_loaded", loaded, 1'b0);
        checkBit("rdstart_ready", load_ready, 1'b1);

        // Abort after 37 accepts; the weight offered with the restart is dropped.
        for (int k = 0; k < 37; k++) push(k, 8'h11);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
        step();
        load_start = 1'b0; load_valid = 1'b0;
        checkBit("abort_ready", load_ready, 1'b1);
        checkBit("abort_loaded", loaded, 1'b0);
        doneCnt = 0;
        for (int k = 0; k < 100; k++) push(k, 8'hA5);
        step();
        checkInt("abort_done_count", doneCnt, 1);
        checkBit("abort_loaded_final", loaded, 1'b1);
        streamCheck("abortrd", 1'b1);

        // Gapped load: valid alternates 1/0.
        startLoad();
        doneCnt = 0; early = 1'b0;
        for (int k = 0; k < 100; k++) begin
            push(k, 8'(k + 100));
            if (k < 99 && loaded) early = 1'b1;
            step();
            if (k < 99 && (loaded || !load_ready)) early = 1'b1;
        end
        checkBit("gap_early_loaded", early, 1'b0);
        checkInt("gap_done_count", doneCnt, 1);
        checkBit("gap_loaded", loaded, 1'b1);
        load_valid = 1'b1; load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        streamCheck("gaprd", 1'b0);

        // Reset in the middle of a load.
        startLoad();
        for (int k = 0; k < 50; k++) push(k, 8'h3C);
        reset = 1'b1; load_valid = 1'b1; load_data = 8'h00;
        step();
        reset = 1'b0; load_valid = 1'b0;
        checkBit("midrst_ready", load_ready, 1'b0);
        checkBit("midrst_loaded", loaded, 1'b0);
        checkBit("midrst_rd_valid", rd_valid, 1'b0);
        checkData("midrst_rd_data", rd_data, 80'h0);
        rd_en = 1'b1; rd_node = 4'd0;
        step();
        rd_en = 1'b0;
        checkBit("midrst_rd_error", rd_error, 1'b1);
        checkBit("midrst_rd_valid2", rd_valid, 1'b0);
        checkData("midrst_rd_data2", rd_data, 80'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
